// File: rtl/pgm_ddram_loader.sv
// rtl/pgm_ddram_loader.sv - packs the 16-bit HPS ioctl download stream into 64-bit DDRAM quadword writes
module pgm_ddram_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned REGION_SHIFT = 24,
  parameter int unsigned NUM_REGIONS  = 4,
  parameter bit          SWAP_BYTES   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic        ddram_we,
  output logic [3:0]  ddram_burstcnt,
  input  logic        ddram_busy,
  output logic        load_done,
  output logic [23:0] words_written
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] pdata_q, pdata_d;
  logic [7:0]  pbe_q, pbe_d;
  logic [28:0] ptag_q, ptag_d;
  logic        pvalid_q, pvalid_d;
  logic        we_q, we_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic [23:0] cnt_q, cnt_d;

  logic [31:0] byte_addr;
  logic [28:0] s_tag;
  logic [1:0]  s_lane;
  logic [15:0] s_word;
  logic        idx_ok, strobe, out_free, accept, tag_hit;
  logic        full_flush, miss_flush, old_out, drain_req, merge_flush, cnt_clr;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  logic [28:0] m_tag;
  logic        m_valid;
  logic        unused_bits;

  assign byte_addr   = BASE_ADDR + (32'(ioctl_index) << REGION_SHIFT) + {5'd0, ioctl_addr[26:1], 1'b0};
  assign s_tag       = byte_addr[31:3];
  assign s_lane      = ioctl_addr[2:1];
  assign s_word      = SWAP_BYTES ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
  assign idx_ok      = 32'(ioctl_index) < NUM_REGIONS;
  assign unused_bits = ^{byte_addr[2:0], ioctl_addr[0]};

  assign strobe     = (state_q == S_LOAD) && ioctl_wr && idx_ok;
  assign out_free   = !we_q || !ddram_busy;
  assign accept     = we_q && !ddram_busy;
  assign tag_hit    = pvalid_q && (ptag_q == s_tag);
  assign full_flush = pvalid_q && (pbe_q == 8'hFF) && out_free;
  assign miss_flush = strobe && pvalid_q && !tag_hit && out_free;
  assign old_out    = full_flush || miss_flush;
  assign drain_req  = ((state_q == S_LOAD) && !ioctl_download) || (state_q == S_DRAIN);

  // Pack contents after this cycle's strobe; the registered pack leaves first if it is displaced.
  always_comb begin
    m_data  = pdata_q;
    m_be    = pbe_q;
    m_tag   = ptag_q;
    m_valid = pvalid_q;
    if (old_out) begin
      m_data  = '0;
      m_be    = '0;
      m_valid = 1'b0;
    end
    if (strobe) begin
      if (!m_valid || !tag_hit) begin
        m_data = '0;
        m_be   = '0;
      end
      m_data[16*s_lane +: 16] = s_word;
      m_be[2*s_lane +: 2]     = 2'b11;
      m_tag                   = s_tag;
      m_valid                 = 1'b1;
    end
  end

  // A word arriving together with the download fall is merged before the pack is written out.
  assign merge_flush = !old_out && drain_req && m_valid && out_free;

  always_comb begin
    pdata_d  = m_data;
    pbe_d    = m_be;
    ptag_d   = m_tag;
    pvalid_d = m_valid;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    be_d     = be_q;
    if (merge_flush) begin
      pdata_d  = '0;
      pbe_d    = '0;
      pvalid_d = 1'b0;
    end
    if (accept) we_d = 1'b0;
    if (old_out) begin
      we_d   = 1'b1;
      addr_d = ptag_q;
      din_d  = pdata_q;
      be_d   = pbe_q;
    end else if (merge_flush) begin
      we_d   = 1'b1;
      addr_d = m_tag;
      din_d  = m_data;
      be_d   = m_be;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ioctl_download) begin
          state_d = S_LOAD;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A new download during the drain restarts loading without a done pulse.
        if (!pvalid_q && out_free) begin
          if (ioctl_download) begin
            state_d = S_LOAD;
            cnt_clr = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 24'hFF_FFFF)) cnt_d = cnt_q + 24'd1;
    if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pdata_q  <= '0;
      pbe_q    <= '0;
      ptag_q   <= '0;
      pvalid_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pdata_q  <= pdata_d;
      pbe_q    <= pbe_d;
      ptag_q   <= ptag_d;
      pvalid_q <= pvalid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ioctl_wait     = we_q;
  assign ddram_we       = we_q;
  assign ddram_addr     = addr_q;
  assign ddram_din      = din_q;
  assign ddram_be       = be_q;
  assign ddram_burstcnt = 4'd1;
  assign load_done      = (state_q == S_DONE);
  assign words_written  = cnt_q;

endmodule

// File: tb/tb_pgm_ddram_loader.sv
// tb/tb_pgm_ddram_loader.sv - directed scoreboard bench for pgm_ddram_loader
module tb_pgm_ddram_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic [3:0]  ddram_burstcnt;
  logic        ddram_busy;
  logic        load_done;
  logic [23:0] words_written;

  always #5 clk = ~clk;

  pgm_ddram_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ddram_addr     (ddram_addr),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be),
    .ddram_we       (ddram_we),
    .ddram_burstcnt (ddram_burstcnt),
    .ddram_busy     (ddram_busy),
    .load_done      (load_done),
    .words_written  (words_written)
  );

  typedef struct {
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [28:0] qaddr(input logic [7:0] idx, input logic [26:0] a);
    logic [31:0] b;
    b = 32'h3000_0000 + ({24'd0, idx} << 24) + ({5'd0, a} & ~32'h1);
    return b[31:3];
  endfunction

  function automatic wr_t mk(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_t w;
    w.addr = a;
    w.din  = d;
    w.be   = be;
    return w;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (reset_n && ddram_we && !ddram_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_write: observed write addr %0h be %0h, expected no write", ddram_addr, ddram_be);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", ddram_addr, e.addr);
        chk("wr_be", ddram_be, e.be);
        chk("wr_din", ddram_din & be_mask(e.be), e.din & be_mask(e.be));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [26:0] a, input logic [15:0] d, input logic [7:0] idx);
    int n = 0;
    while (ioctl_wait && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) chk("strobe_wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_cyc, done_cyc, done_cnt, we_cnt;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    ddram_busy     = 1'b0;
    tick(3);
    chk("rst_we", ddram_we, 0);
    chk("rst_burstcnt", ddram_burstcnt, 1);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", load_done, 0);
    chk("rst_words", words_written, 0);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_be", ddram_be, 0);
    reset_n = 1'b1;
    tick(2);

    // full quadword
    ioctl_download = 1'b1;
    tick(2);
    exp_q.push_back(mk(qaddr(0, 0), 64'h4444_3333_2222_1111, 8'hFF));
    strobe(0, 16'h1111, 0);
    strobe(2, 16'h2222, 0);
    strobe(4, 16'h3333, 0);
    strobe(6, 16'h4444, 0);
    tick(3);
    chk("t1_words", words_written, 1);

    // tag miss flushes a partial pack
    exp_q.push_back(mk(qaddr(0, 8), 64'h0000_0000_2222_1111, 8'h0F));
    strobe(8, 16'h1111, 0);
    strobe(10, 16'h2222, 0);
    strobe(40, 16'h5555, 0);
    tick(2);
    chk("t2_words", words_written, 2);
    chk("t2_we_idle", ddram_we, 0);

    // busy back-pressure
    strobe(42, 16'h6666, 0);
    strobe(44, 16'h7777, 0);
    exp_q.push_back(mk(qaddr(0, 40), 64'h8888_7777_6666_5555, 8'hFF));
    ddram_busy = 1'b1;
    strobe(46, 16'h8888, 0);
    n = 0;
    while (!ddram_we && n < 10) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ddram_busy = 1'b0;
      chk("busy_we", ddram_we, 1);
      chk("busy_wait", ioctl_wait, 1);
      chk("busy_addr", ddram_addr, qaddr(0, 40));
      chk("busy_din", ddram_din, 64'h8888_7777_6666_5555);
      chk("busy_be", ddram_be, 8'hFF);
      if (i < 5) tick(1);
    end
    tick(1);
    chk("busy_we_drop", ddram_we, 0);
    chk("busy_words", words_written, 3);

    // download ends with a 3-word pack
    strobe(48, 16'hAAAA, 0);
    strobe(50, 16'hBBBB, 0);
    strobe(52, 16'hCCCC, 0);
    exp_q.push_back(mk(qaddr(0, 48), 64'h0000_CCCC_BBBB_AAAA, 8'h3F));
    ioctl_download = 1'b0;
    acc_cyc = -1; done_cyc = -1; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (ddram_we && !ddram_busy) acc_cyc = c;
      if (load_done) begin
        done_cnt++;
        done_cyc = c;
      end
      tick(1);
    end
    chk("t4_write_seen", 64'(acc_cyc >= 0), 1);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_done_latency", done_cyc, acc_cyc + 1);
    chk("t4_words", words_written, 4);

    // out-of-range index is ignored
    ioctl_download = 1'b1;
    tick(2);
    chk("t5_words_cleared", words_written, 0);
    strobe(0, 16'hDEAD, 5);
    strobe(2, 16'hBEEF, 5);
    strobe(4, 16'hCAFE, 5);
    strobe(6, 16'hF00D, 5);
    tick(2);
    ioctl_download = 1'b0;
    we_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (ddram_we) we_cnt++;
      if (load_done) done_cnt++;
      tick(1);
    end
    chk("t5_no_we", we_cnt, 0);
    chk("t5_done_count", done_cnt, 1);
    chk("t5_words", words_written, 0);

    // reset while a write is stalled
    ioctl_download = 1'b1;
    tick(2);
    ddram_busy = 1'b1;
    strobe(0, 16'h0101, 0);
    strobe(2, 16'h0202, 0);
    strobe(4, 16'h0303, 0);
    strobe(6, 16'h0404, 0);
    n = 0;
    while (!ddram_we && n < 10) begin
      tick(1);
      n++;
    end
    chk("t6_we_before_rst", ddram_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_we", ddram_we, 0);
    chk("t6_rst_wait", ioctl_wait, 0);
    chk("t6_rst_words", words_written, 0);
    ioctl_download = 1'b0;
    ddram_busy     = 1'b0;
    tick(2);
    reset_n = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (ddram_we) we_cnt++;
      if (load_done) done_cnt++;
      tick(1);
    end
    chk("t6_no_reissue", we_cnt, 0);
    chk("t6_no_done", done_cnt, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
